smart_cargo_uc: RTL and testbench

SMART_CARGO_UC -- requirements
Module: smart_cargo_uc

---
 rtl/smart_cargo_uc.sv | 150 +++++++++++++++
 tb/tb_smart_cargo_uc.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/smart_cargo_uc.sv
// Control unit for a cargo elevator: serial request capture into a bounded queue,
// trip sequencing (move, door open, load/unload, queue advance) and occupancy tracking.
module smart_cargo_uc #(
    parameter int FILA_MAX = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       bordaNovoDestino,
    input  logic       temDestino,
    input  logic       chegouDestino,
    input  logic       sobe,
    input  logic       fimT,
    input  logic       eh_origem_fila,
    output logic       enableRegDestino,
    output logic       enableRAM,
    output logic       shift,
    output logic       zeraT,
    output logic       contaT,
    output logic       coloca_objetos,
    output logic       tira_objetos,
    output logic       motor_sobe,
    output logic       motor_desce,
    output logic       porta_aberta,
    output logic       inicia_ultrasonico,
    output logic [3:0] ocupacao,
    output logic       erro_fila,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        ESPERA    = 4'd1,
        REGISTRA  = 4'd2,
        ARMAZENA  = 4'd3,
        DECIDE    = 4'd4,
        MOVE      = 4'd5,
        ABRE      = 4'd6,
        PORTA     = 4'd7,
        TRANSFERE = 4'd8,
        AVANCA    = 4'd9
    } state_t;

    localparam logic [3:0] FILA_LIMITE = 4'(FILA_MAX);

    // Plain vector register so codes outside the enum (10..15) stay representable.
    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic       pendente;
    logic       fila_cheia;

    assign fila_cheia = (ocupacao >= FILA_LIMITE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= INICIAL;
        end else begin
            state_reg <= state_next;
        end
    end

    // A new pulse always wins over the clear in REGISTRA, so no request is lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pendente <= 1'b0;
        end else if (bordaNovoDestino) begin
            pendente <= 1'b1;
        end else if (state_reg == REGISTRA) begin
            pendente <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ocupacao  <= 4'd0;
            erro_fila <= 1'b0;
        end else if (state_reg == ARMAZENA) begin
            if (fila_cheia) begin
                erro_fila <= 1'b1;
            end else begin
                ocupacao <= ocupacao + 4'd1;
            end
        end else if (state_reg == AVANCA && ocupacao != 4'd0) begin
            ocupacao <= ocupacao - 4'd1;
        end
    end

    always_comb begin
        state_next = INICIAL;
        case (state_reg)
            INICIAL:   state_next = iniciar ? ESPERA : INICIAL;
            ESPERA: begin
                if (pendente)        state_next = REGISTRA;
                else if (temDestino) state_next = DECIDE;
                else                 state_next = ESPERA;
            end
            REGISTRA:  state_next = ARMAZENA;
            ARMAZENA:  state_next = DECIDE;
            DECIDE: begin
                if (pendente)                          state_next = REGISTRA;
                else if (temDestino && !chegouDestino) state_next = MOVE;
                else if (temDestino && chegouDestino)  state_next = ABRE;
                else                                   state_next = ESPERA;
            end
            MOVE:      state_next = chegouDestino ? ABRE : MOVE;
            ABRE:      state_next = PORTA;
            PORTA:     state_next = fimT ? TRANSFERE : PORTA;
            TRANSFERE: state_next = AVANCA;
            AVANCA:    state_next = DECIDE;
            default:   state_next = INICIAL;
        endcase
    end

    always_comb begin
        enableRegDestino   = 1'b0;
        enableRAM          = 1'b0;
        shift              = 1'b0;
        zeraT              = 1'b0;
        contaT             = 1'b0;
        coloca_objetos     = 1'b0;
        tira_objetos       = 1'b0;
        motor_sobe         = 1'b0;
        motor_desce        = 1'b0;
        porta_aberta       = 1'b0;
        inicia_ultrasonico = 1'b0;
        case (state_reg)
            REGISTRA:  enableRegDestino = 1'b1;
            ARMAZENA:  enableRAM = !fila_cheia;
            MOVE: begin
                inicia_ultrasonico = 1'b1;
                motor_sobe         = sobe;
                motor_desce        = !sobe;
            end
            ABRE:      zeraT = 1'b1;
            PORTA: begin
                contaT       = 1'b1;
                porta_aberta = 1'b1;
            end
            TRANSFERE: begin
                coloca_objetos = eh_origem_fila;
                tira_objetos   = !eh_origem_fila;
            end
            AVANCA:    shift = 1'b1;
            default:   ;
        endcase
    end

    assign db_estado = state_reg;

endmodule

// File: tb/tb_smart_cargo_uc.sv
// Directed table-driven bench for smart_cargo_uc with a two-entry queue, plus
// hand sequences for asynchronous reset during PORTA and recovery from an illegal state code.
module tb_smart_cargo_uc;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       bordaNovoDestino = 1'b0;
    logic       temDestino = 1'b0;
    logic       chegouDestino = 1'b0;
    logic       sobe = 1'b0;
    logic       fimT = 1'b0;
    logic       eh_origem_fila = 1'b0;
    logic       enableRegDestino, enableRAM, shift, zeraT, contaT;
    logic       coloca_objetos, tira_objetos, motor_sobe, motor_desce;
    logic       porta_aberta, inicia_ultrasonico;
    logic [3:0] ocupacao;
    logic       erro_fila;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;

    smart_cargo_uc #(.FILA_MAX(2)) dut (
        .clock              (clock),
        .reset              (reset),
        .iniciar            (iniciar),
        .bordaNovoDestino   (bordaNovoDestino),
        .temDestino         (temDestino),
        .chegouDestino      (chegouDestino),
        .sobe               (sobe),
        .fimT               (fimT),
        .eh_origem_fila     (eh_origem_fila),
        .enableRegDestino   (enableRegDestino),
        .enableRAM          (enableRAM),
        .shift              (shift),
        .zeraT              (zeraT),
        .contaT             (contaT),
        .coloca_objetos     (coloca_objetos),
        .tira_objetos       (tira_objetos),
        .motor_sobe         (motor_sobe),
        .motor_desce        (motor_desce),
        .porta_aberta       (porta_aberta),
        .inicia_ultrasonico (inicia_ultrasonico),
        .ocupacao           (ocupacao),
        .erro_fila          (erro_fila),
        .db_estado          (db_estado)
    );

    always #5 clock = ~clock;

    // Strobe bundle bit order:
    // {enableRegDestino, enableRAM, shift, zeraT, contaT, coloca, tira,
    //  motor_sobe, motor_desce, porta_aberta, inicia_ultrasonico}
    localparam logic [10:0] S_NONE  = 11'h000;
    localparam logic [10:0] S_REG   = 11'h400;
    localparam logic [10:0] S_RAM   = 11'h200;
    localparam logic [10:0] S_SHIFT = 11'h100;
    localparam logic [10:0] S_ZERA  = 11'h080;
    localparam logic [10:0] S_PORTA = 11'h042;
    localparam logic [10:0] S_COLOC = 11'h020;
    localparam logic [10:0] S_TIRA  = 11'h010;
    localparam logic [10:0] S_UP    = 11'h009;
    localparam logic [10:0] S_DOWN  = 11'h005;

    typedef struct {
        logic [6:0]  inputs;   // {iniciar, borda, temDestino, chegou, sobe, fimT, eh_origem}
        logic [3:0]  estado;
        logic [10:0] strobes;
        logic [3:0]  ocup;
        logic        erro;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [10:0] strobes_now();
        return {enableRegDestino, enableRAM, shift, zeraT, contaT, coloca_objetos,
                tira_objetos, motor_sobe, motor_desce, porta_aberta, inicia_ultrasonico};
    endfunction

    task automatic add(input logic [6:0] in, input logic [3:0] st, input logic [10:0] sb,
                       input logic [3:0] oc, input logic er);
        vec_t v;
        v.inputs = in; v.estado = st; v.strobes = sb; v.ocup = oc; v.erro = er;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [10:0] actual, input logic [10:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] st, input logic [10:0] sb,
                             input logic [3:0] oc, input logic er);
        check({tag, " db_estado"}, {7'd0, db_estado}, {7'd0, st});
        check({tag, " strobes"}, strobes_now(), sb);
        check({tag, " ocupacao"}, {7'd0, ocupacao}, {7'd0, oc});
        check({tag, " erro_fila"}, {10'd0, erro_fila}, {10'd0, er});
    endtask

    initial begin
        // Single request, then a pickup trip with a request arriving mid-MOVE.
        add(7'b0000000, 4'd0, S_NONE,  4'd0, 1'b0);
        add(7'b1000000, 4'd1, S_NONE,  4'd0, 1'b0);
        add(7'b1100000, 4'd1, S_NONE,  4'd0, 1'b0);
        add(7'b1000000, 4'd2, S_REG,   4'd0, 1'b0);
        add(7'b1000000, 4'd3, S_RAM,   4'd0, 1'b0);
        add(7'b1000000, 4'd4, S_NONE,  4'd1, 1'b0);
        add(7'b1000000, 4'd1, S_NONE,  4'd1, 1'b0);
        add(7'b1010100, 4'd4, S_NONE,  4'd1, 1'b0);
        add(7'b1010100, 4'd5, S_UP,    4'd1, 1'b0);
        add(7'b1110100, 4'd5, S_UP,    4'd1, 1'b0);
        add(7'b1010100, 4'd5, S_UP,    4'd1, 1'b0);
        add(7'b1011100, 4'd6, S_ZERA,  4'd1, 1'b0);
        add(7'b1011100, 4'd7, S_PORTA, 4'd1, 1'b0);
        add(7'b1011100, 4'd7, S_PORTA, 4'd1, 1'b0);
        add(7'b1011111, 4'd8, S_COLOC, 4'd1, 1'b0);
        add(7'b1000000, 4'd9, S_SHIFT, 4'd1, 1'b0);
        add(7'b1000000, 4'd4, S_NONE,  4'd0, 1'b0);
        add(7'b1000000, 4'd2, S_REG,   4'd0, 1'b0);
        add(7'b1000000, 4'd3, S_RAM,   4'd0, 1'b0);
        add(7'b1000000, 4'd4, S_NONE,  4'd1, 1'b0);
        // Fill to the limit of two, then overflow on the third store.
        add(7'b1100000, 4'd1, S_NONE,  4'd1, 1'b0);
        add(7'b1000000, 4'd2, S_REG,   4'd1, 1'b0);
        add(7'b1000000, 4'd3, S_RAM,   4'd1, 1'b0);
        add(7'b1000000, 4'd4, S_NONE,  4'd2, 1'b0);
        add(7'b1100000, 4'd1, S_NONE,  4'd2, 1'b0);
        add(7'b1000000, 4'd2, S_REG,   4'd2, 1'b0);
        add(7'b1000000, 4'd3, S_NONE,  4'd2, 1'b0);
        add(7'b1000000, 4'd4, S_NONE,  4'd2, 1'b1);
        add(7'b1000000, 4'd1, S_NONE,  4'd2, 1'b1);
        // Delivery trip downward, then a direct DECIDE -> ABRE when already at target.
        add(7'b1010000, 4'd4, S_NONE,  4'd2, 1'b1);
        add(7'b1010000, 4'd5, S_DOWN,  4'd2, 1'b1);
        add(7'b1011000, 4'd6, S_ZERA,  4'd2, 1'b1);
        add(7'b1011000, 4'd7, S_PORTA, 4'd2, 1'b1);
        add(7'b1011010, 4'd8, S_TIRA,  4'd2, 1'b1);
        add(7'b1000000, 4'd9, S_SHIFT, 4'd2, 1'b1);
        add(7'b1011000, 4'd4, S_NONE,  4'd1, 1'b1);
        add(7'b1011000, 4'd6, S_ZERA,  4'd1, 1'b1);
        add(7'b1011000, 4'd7, S_PORTA, 4'd1, 1'b1);
        add(7'b1011000, 4'd7, S_PORTA, 4'd1, 1'b1);

        #12;
        check_all("reset", 4'd0, S_NONE, 4'd0, 1'b0);
        $display("reset held: db_estado=%0d ocupacao=%0d erro_fila=%0d", db_estado, ocupacao, erro_fila);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            {iniciar, bordaNovoDestino, temDestino, chegouDestino, sobe, fimT, eh_origem_fila} = vecs[i].inputs;
            @(posedge clock);
            @(negedge clock);
            check_all($sformatf("vec%0d", i), vecs[i].estado, vecs[i].strobes, vecs[i].ocup, vecs[i].erro);
            $display("vec%0d: in=%b db_estado=%0d strobes=%h ocupacao=%0d erro_fila=%0d",
                     i, vecs[i].inputs, db_estado, strobes_now(), ocupacao, erro_fila);
        end

        // Asynchronous reset between edges while the door is open.
        #2;
        reset = 1'b0;
        #1;
        check_all("async_reset", 4'd0, S_NONE, 4'd0, 1'b0);
        $display("async reset in PORTA: db_estado=%0d porta_aberta=%0d", db_estado, porta_aberta);
        @(negedge clock);
        iniciar = 1'b0; temDestino = 1'b0; chegouDestino = 1'b0;
        reset = 1'b1;

        // Illegal state code returns to INICIAL with all strobes low.
        @(negedge clock);
        force dut.state_reg = 4'd12;
        #1;
        check("illegal db_estado", {7'd0, db_estado}, 11'd12);
        check("illegal strobes", strobes_now(), S_NONE);
        release dut.state_reg;
        @(posedge clock);
        #1;
        check("recover db_estado", {7'd0, db_estado}, 11'd0);
        check("recover strobes", strobes_now(), S_NONE);
        $display("illegal state 12 recovered: db_estado=%0d", db_estado);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
